// File: rtl/life_gen_controller.sv
// Game-of-Life sequencer: clear sweep, user loads, generation pacing and
// change-list drain onto the shared VGA plot and cell-store write ports.
module life_gen_controller #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter int         GEN_PERIOD   = 5000000,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        step,
  input  logic        clear_req,
  input  logic        load_valid,
  input  logic [7:0]  load_x,
  input  logic [6:0]  load_y,
  output logic        load_ready,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        eng_empty,
  input  logic        chg_valid,
  input  logic [7:0]  chg_x,
  input  logic [6:0]  chg_y,
  input  logic        chg_alive,
  input  logic        chg_last,
  output logic        chg_ready,
  output logic        cell_we,
  output logic [7:0]  cell_x,
  output logic [6:0]  cell_y,
  output logic        cell_d,
  output logic        plot,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam int TW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD + 1) : 1;
  localparam logic [TW-1:0] TL = TW'(GEN_PERIOD - 1);
  localparam logic [7:0] XL = 8'(WIDTH - 1);
  localparam logic [6:0] YL = 7'(HEIGHT - 1);
  localparam logic [8:0] WX = 9'(WIDTH);
  localparam logic [7:0] HY = 8'(HEIGHT);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t state, state_n;

  logic          pending, pending_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   gen_n;
  logic          plot_n, cell_d_n, eng_start_n;
  logic [7:0]    x_n;
  logic [6:0]    y_n;
  logic [2:0]    colour_n;
  logic          load_ok, chg_ok;

  assign load_ok = ({1'b0, load_x} < WX) && ({1'b0, load_y} < HY);
  assign chg_ok  = ({1'b0, chg_x} < WX) && ({1'b0, chg_y} < HY);

  always_comb begin
    state_n     = state;
    pending_n   = pending | clear_req;
    timer_n     = (timer < TL) ? timer + TW'(1) : timer;
    gen_n       = gen_count;
    plot_n      = 1'b0;
    cell_d_n    = 1'b0;
    eng_start_n = 1'b0;
    x_n         = x;
    y_n         = y;
    colour_n    = 3'b000;
    unique case (state)
      S_CLEAR: begin
        colour_n = DEAD_COLOUR;
        // plot low here means the sweep has not emitted its first pixel yet
        if (!plot) begin
          plot_n = 1'b1;
          x_n    = '0;
          y_n    = '0;
        end else if (x == XL && y == YL) begin
          state_n   = S_IDLE;
          pending_n = 1'b0;
          gen_n     = '0;
        end else begin
          plot_n = 1'b1;
          if (x == XL) begin
            x_n = '0;
            y_n = y + 7'd1;
          end else begin
            x_n = x + 8'd1;
          end
        end
      end
      S_IDLE: begin
        if (pending) begin
          state_n  = S_CLEAR;
          plot_n   = 1'b1;
          x_n      = '0;
          y_n      = '0;
          colour_n = DEAD_COLOUR;
        end else if (load_valid && load_ready) begin
          state_n = S_LOAD;
          if (load_ok) begin
            plot_n   = 1'b1;
            x_n      = load_x;
            y_n      = load_y;
            cell_d_n = 1'b1;
            colour_n = ALIVE_COLOUR;
          end
        end else if (step || (start && timer >= TL)) begin
          state_n     = S_COMPUTE;
          eng_start_n = 1'b1;
          timer_n     = '0;
        end
      end
      S_LOAD: begin
        state_n = S_IDLE;
      end
      S_COMPUTE: begin
        if (eng_done) begin
          if (eng_empty) begin
            gen_n   = gen_count + 16'd1;
            state_n = S_IDLE;
          end else begin
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (chg_valid && chg_ready) begin
          if (chg_ok) begin
            plot_n   = 1'b1;
            x_n      = chg_x;
            y_n      = chg_y;
            cell_d_n = chg_alive;
            colour_n = chg_alive ? ALIVE_COLOUR : DEAD_COLOUR;
          end
          if (chg_last) begin
            gen_n   = gen_count + 16'd1;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      pending    <= 1'b0;
      timer      <= '0;
      gen_count  <= '0;
      plot       <= 1'b0;
      cell_we    <= 1'b0;
      x          <= '0;
      y          <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      colour     <= '0;
      cell_d     <= 1'b0;
      eng_start  <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b0;
      chg_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      timer      <= timer_n;
      gen_count  <= gen_n;
      plot       <= plot_n;
      cell_we    <= plot_n;
      x          <= x_n;
      y          <= y_n;
      cell_x     <= x_n;
      cell_y     <= y_n;
      colour     <= colour_n;
      cell_d     <= cell_d_n;
      eng_start  <= eng_start_n;
      busy       <= (state_n != S_IDLE);
      load_ready <= (state_n == S_IDLE) && !pending_n;
      chg_ready  <= (state_n == S_DRAIN);
    end
  end

endmodule
